// File: rtl/bp_nonsynth_commit_driver_if.sv
// Bundles the table-load inputs and the commit/writeback event stream of the commit driver.
interface bp_nonsynth_commit_driver_if #(
    parameter int unsigned vaddr_width_p = 39,
    parameter int unsigned els_p         = 64
);
    localparam int unsigned addr_w_lp = $clog2(els_p);
    localparam int unsigned rec_w_lp  = 4 + 3 + 5 + vaddr_width_p + 32 + 64;

    // Table load and replay control
    logic                     w_v_i;
    logic [addr_w_lp-1:0]     w_addr_i;
    logic [rec_w_lp-1:0]      w_data_i;
    logic                     start_i;

    // Event stream toward the cosim checker
    logic                     commit_v_o;
    logic [vaddr_width_p-1:0] commit_pc_o;
    logic [31:0]              commit_instr_o;
    logic                     ird_w_v_o;
    logic [4:0]               ird_addr_o;
    logic [63:0]              ird_data_o;
    logic                     frd_w_v_o;
    logic [4:0]               frd_addr_o;
    logic [63:0]              frd_data_o;
    logic                     trap_v_o;
    logic [63:0]              cause_o;
    logic                     done_o;
    logic [31:0]              commit_cnt_o;

    // Driver side
    modport master (
        input  w_v_i, w_addr_i, w_data_i, start_i,
        output commit_v_o, commit_pc_o, commit_instr_o,
        output ird_w_v_o, ird_addr_o, ird_data_o,
        output frd_w_v_o, frd_addr_o, frd_data_o,
        output trap_v_o, cause_o, done_o, commit_cnt_o
    );

    // Harness / consumer side
    modport slave (
        output w_v_i, w_addr_i, w_data_i, start_i,
        input  commit_v_o, commit_pc_o, commit_instr_o,
        input  ird_w_v_o, ird_addr_o, ird_data_o,
        input  frd_w_v_o, frd_addr_o, frd_data_o,
        input  trap_v_o, cause_o, done_o, commit_cnt_o
    );
endinterface

// File: rtl/bp_nonsynth_commit_driver.sv
// Replays a preloaded table of commit records as commit pulses, early/late int and FP
// writebacks and traps. Writebacks stay in commit order within each register file.
module bp_nonsynth_commit_driver #(
    parameter int unsigned vaddr_width_p = 39,
    parameter int unsigned els_p         = 64,
    // Cycles from a late commit to its writeback, 1..15
    parameter int unsigned late_delay_p  = 3
) (
    input logic                         clk_i,
    input logic                         reset_i,
    bp_nonsynth_commit_driver_if.master bus
);
    localparam int unsigned addr_w_lp = $clog2(els_p);
    localparam int unsigned rec_w_lp  = 4 + 3 + 5 + vaddr_width_p + 32 + 64;

    // Record field offsets, data at the LSB end
    localparam int unsigned instr_lsb_lp = 64;
    localparam int unsigned pc_lsb_lp    = 96;
    localparam int unsigned rd_lsb_lp    = pc_lsb_lp + vaddr_width_p;
    localparam int unsigned kind_lsb_lp  = rd_lsb_lp + 5;
    localparam int unsigned gap_lsb_lp   = kind_lsb_lp + 3;

    localparam logic [addr_w_lp:0] idx_end_lp = (addr_w_lp + 1)'(els_p);
    localparam logic [addr_w_lp:0] idx_one_lp = (addr_w_lp + 1)'(1);
    localparam logic [3:0]         late_lp    = 4'(late_delay_p);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StGap   = 3'd1;
    localparam logic [2:0] StIssue = 3'd2;
    localparam logic [2:0] StDrain = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    localparam logic [2:0] KindNone    = 3'd0;
    localparam logic [2:0] KindIntEarly = 3'd1;
    localparam logic [2:0] KindFpEarly = 3'd2;
    localparam logic [2:0] KindIntLate = 3'd3;
    localparam logic [2:0] KindFpLate  = 3'd4;
    localparam logic [2:0] KindTrap    = 3'd5;

    logic [rec_w_lp-1:0] mem [els_p];

    logic [2:0]           state_q, state_d;
    logic [addr_w_lp:0]   idx_q, idx_d;
    logic [3:0]           gap_q, gap_d;

    // Late writeback slots, one per register file
    logic                 iv_q, iv_d, fv_q, fv_d;
    logic [3:0]           icnt_q, icnt_d, fcnt_q, fcnt_d;
    logic [4:0]           ird_q, ird_d, frd_q, frd_d;
    logic [63:0]          idata_q, idata_d, fdata_q, fdata_d;

    logic                     commit_v_q, ird_w_v_q, frd_w_v_q, trap_v_q, done_q;
    logic [vaddr_width_p-1:0] commit_pc_q;
    logic [31:0]              commit_instr_q, commit_cnt_q;
    logic [4:0]               ird_addr_q, frd_addr_q;
    logic [63:0]              ird_data_q, frd_data_q, cause_q;

    logic [rec_w_lp-1:0]      cur_rec;
    logic [2:0]               kind;
    logic [4:0]               rec_rd;
    logic [vaddr_width_p-1:0] rec_pc;
    logic [31:0]              rec_instr;
    logic [63:0]              rec_data;
    logic [addr_w_lp:0]       idx_nxt;
    logic [3:0]               gap_nxt;
    logic                     at_end, stall, issue, ifire, ffire;

    assign cur_rec   = mem[idx_q[addr_w_lp-1:0]];
    assign kind      = cur_rec[kind_lsb_lp +: 3];
    assign rec_rd    = cur_rec[rd_lsb_lp +: 5];
    assign rec_pc    = cur_rec[pc_lsb_lp +: vaddr_width_p];
    assign rec_instr = cur_rec[instr_lsb_lp +: 32];
    assign rec_data  = cur_rec[63:0];

    assign idx_nxt = idx_q + idx_one_lp;
    assign gap_nxt = (idx_nxt == idx_end_lp) ? 4'd0
                                             : mem[idx_nxt[addr_w_lp-1:0]][gap_lsb_lp +: 4];

    assign at_end = (idx_q == idx_end_lp) || (kind >= 3'd6);
    // A record waits while its own class has a late write in flight, including the
    // cycle that write is being launched, so per-file writeback order matches commit order.
    assign stall  = (((kind == KindIntEarly) || (kind == KindIntLate)) && iv_q) ||
                    (((kind == KindFpEarly) || (kind == KindFpLate)) && fv_q);
    assign ifire  = iv_q && (icnt_q == 4'd1);
    assign ffire  = fv_q && (fcnt_q == 4'd1);

    // Record table: loadable only while idle, kept across reset
    always_ff @(posedge clk_i) begin
        if (bus.w_v_i && (state_q == StIdle)) begin
            mem[bus.w_addr_i] <= bus.w_data_i;
        end
    end

    // Next-state: replay sequencing and late slot countdown
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        issue   = 1'b0;
        iv_d    = iv_q;
        icnt_d  = icnt_q;
        ird_d   = ird_q;
        idata_d = idata_q;
        fv_d    = fv_q;
        fcnt_d  = fcnt_q;
        frd_d   = frd_q;
        fdata_d = fdata_q;

        if (iv_q) begin
            if (ifire) iv_d = 1'b0;
            else       icnt_d = icnt_q - 4'd1;
        end
        if (fv_q) begin
            if (ffire) fv_d = 1'b0;
            else       fcnt_d = fcnt_q - 4'd1;
        end

        case (state_q)
            StIdle: begin
                if (bus.start_i) begin
                    idx_d   = '0;
                    gap_d   = mem[0][gap_lsb_lp +: 4];
                    state_d = (gap_d == 4'd0) ? StIssue : StGap;
                end
            end
            StGap: begin
                if (gap_q <= 4'd1) state_d = StIssue;
                else               gap_d = gap_q - 4'd1;
            end
            StIssue: begin
                if (at_end) begin
                    state_d = StDrain;
                end else if (!stall) begin
                    issue   = 1'b1;
                    idx_d   = idx_nxt;
                    gap_d   = gap_nxt;
                    state_d = (gap_nxt == 4'd0) ? StIssue : StGap;
                end
            end
            StDrain: begin
                if (!iv_q && !fv_q) state_d = StDone;
            end
            StDone: begin
                state_d = StDone;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (issue && (kind == KindIntLate)) begin
            iv_d    = 1'b1;
            icnt_d  = late_lp;
            ird_d   = rec_rd;
            idata_d = rec_data;
        end
        if (issue && (kind == KindFpLate)) begin
            fv_d    = 1'b1;
            fcnt_d  = late_lp;
            frd_d   = rec_rd;
            fdata_d = rec_data;
        end
    end

    // State, slots and registered event outputs
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q        <= StIdle;
            idx_q          <= '0;
            gap_q          <= '0;
            iv_q           <= 1'b0;
            icnt_q         <= '0;
            ird_q          <= '0;
            idata_q        <= '0;
            fv_q           <= 1'b0;
            fcnt_q         <= '0;
            frd_q          <= '0;
            fdata_q        <= '0;
            commit_v_q     <= 1'b0;
            commit_pc_q    <= '0;
            commit_instr_q <= '0;
            ird_w_v_q      <= 1'b0;
            ird_addr_q     <= '0;
            ird_data_q     <= '0;
            frd_w_v_q      <= 1'b0;
            frd_addr_q     <= '0;
            frd_data_q     <= '0;
            trap_v_q       <= 1'b0;
            cause_q        <= '0;
            done_q         <= 1'b0;
            commit_cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            iv_q    <= iv_d;
            icnt_q  <= icnt_d;
            ird_q   <= ird_d;
            idata_q <= idata_d;
            fv_q    <= fv_d;
            fcnt_q  <= fcnt_d;
            frd_q   <= frd_d;
            fdata_q <= fdata_d;

            commit_v_q <= issue && (kind <= KindFpLate);
            if (issue && (kind <= KindFpLate)) begin
                commit_pc_q    <= rec_pc;
                commit_instr_q <= rec_instr;
                if (commit_cnt_q != '1) commit_cnt_q <= commit_cnt_q + 32'd1;
            end

            // Stall rule guarantees a slot launch and an early write never share a port
            ird_w_v_q <= ifire || (issue && (kind == KindIntEarly));
            if (ifire) begin
                ird_addr_q <= ird_q;
                ird_data_q <= idata_q;
            end else if (issue && (kind == KindIntEarly)) begin
                ird_addr_q <= rec_rd;
                ird_data_q <= rec_data;
            end

            frd_w_v_q <= ffire || (issue && (kind == KindFpEarly));
            if (ffire) begin
                frd_addr_q <= frd_q;
                frd_data_q <= fdata_q;
            end else if (issue && (kind == KindFpEarly)) begin
                frd_addr_q <= rec_rd;
                frd_data_q <= rec_data;
            end

            trap_v_q <= issue && (kind == KindTrap);
            if (issue && (kind == KindTrap)) cause_q <= rec_data;

            done_q <= (state_d == StDone);
        end
    end

    assign bus.commit_v_o     = commit_v_q;
    assign bus.commit_pc_o    = commit_pc_q;
    assign bus.commit_instr_o = commit_instr_q;
    assign bus.ird_w_v_o      = ird_w_v_q;
    assign bus.ird_addr_o     = ird_addr_q;
    assign bus.ird_data_o     = ird_data_q;
    assign bus.frd_w_v_o      = frd_w_v_q;
    assign bus.frd_addr_o     = frd_addr_q;
    assign bus.frd_data_o     = frd_data_q;
    assign bus.trap_v_o       = trap_v_q;
    assign bus.cause_o        = cause_q;
    assign bus.done_o         = done_q;
    assign bus.commit_cnt_o   = commit_cnt_q;

endmodule

// File: tb/tb_bp_nonsynth_commit_driver.sv
// Scoreboard bench for the commit driver: directed tables, expected events queued with
// their cycle offset from the start edge, a negedge monitor pops and compares.
module tb_bp_nonsynth_commit_driver;
    localparam int VW = 39;
    localparam int RW = 4 + 3 + 5 + VW + 32 + 64;

    typedef struct {
        int          rel;
        logic [63:0] a;
        logic [63:0] b;
    } ev_t;

    logic clk = 1'b0;
    logic reset_i;
    int   cyc = 0;
    int   t0 = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    ev_t exp_c[$];
    ev_t exp_i[$];
    ev_t exp_f[$];
    ev_t exp_t[$];

    bp_nonsynth_commit_driver_if #(.vaddr_width_p(VW), .els_p(64)) bus ();

    bp_nonsynth_commit_driver #(
        .vaddr_width_p(VW),
        .els_p        (64),
        .late_delay_p (3)
    ) dut (
        .clk_i  (clk),
        .reset_i(reset_i),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [RW-1:0] mk(logic [3:0] gap, logic [2:0] kind, logic [4:0] rd,
                                         logic [VW-1:0] pc, logic [31:0] instr,
                                         logic [63:0] data);
        return {gap, kind, rd, pc, instr, data};
    endfunction

    function automatic ev_t ev(int rel, logic [63:0] a, logic [63:0] b);
        ev_t e;
        e.rel = rel;
        e.a   = a;
        e.b   = b;
        return e;
    endfunction

    function automatic void score(string nm, bit have, ev_t e, int rel,
                                  logic [63:0] a, logic [63:0] b);
        n_tests++;
        if (!have) begin
            n_fail++;
            $display("FAIL %s unexpected: got rel=%0d a=%h b=%h, required no event",
                     nm, rel, a, b);
        end else if (e.rel != rel || e.a !== a || e.b !== b) begin
            n_fail++;
            $display("FAIL %s: got rel=%0d a=%h b=%h, required rel=%0d a=%h b=%h",
                     nm, rel, a, b, e.rel, e.a, e.b);
        end
    endfunction

    task automatic check(string nm, logic [63:0] got, logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, got, want);
        end
    endtask

    // Monitor: every strobe must match the head of its stream's expected queue
    always @(negedge clk) begin
        int  rel;
        ev_t e;
        bit  have;
        rel = cyc - t0;
        if (bus.commit_v_o) begin
            have = exp_c.size() != 0;
            if (have) e = exp_c.pop_front();
            score("commit", have, e, rel, 64'(bus.commit_pc_o), 64'(bus.commit_instr_o));
        end
        if (bus.ird_w_v_o) begin
            have = exp_i.size() != 0;
            if (have) e = exp_i.pop_front();
            score("ird", have, e, rel, 64'(bus.ird_addr_o), bus.ird_data_o);
        end
        if (bus.frd_w_v_o) begin
            have = exp_f.size() != 0;
            if (have) e = exp_f.pop_front();
            score("frd", have, e, rel, 64'(bus.frd_addr_o), bus.frd_data_o);
        end
        if (bus.trap_v_o) begin
            have = exp_t.size() != 0;
            if (have) e = exp_t.pop_front();
            score("trap", have, e, rel, bus.cause_o, 64'd0);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset_i = 1'b1;
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
    endtask

    task automatic wr(int idx, logic [RW-1:0] rec);
        @(negedge clk);
        bus.w_v_i    = 1'b1;
        bus.w_addr_i = 6'(idx);
        bus.w_data_i = rec;
        @(negedge clk);
        bus.w_v_i    = 1'b0;
    endtask

    // Leaves the caller at the negedge right after the start edge (rel 0)
    task automatic start_run();
        @(negedge clk);
        bus.start_i = 1'b1;
        t0 = cyc + 1;
        @(negedge clk);
        bus.start_i = 1'b0;
    endtask

    task automatic finish_run(string nm, int cnt);
        for (int i = 0; i < 200 && !bus.done_o; i++) @(negedge clk);
        check({nm, "_done"}, 64'(bus.done_o), 64'd1);
        check({nm, "_leftover"}, 64'(exp_c.size() + exp_i.size() + exp_f.size() + exp_t.size()),
              64'd0);
        check({nm, "_cnt"}, 64'(bus.commit_cnt_o), 64'(cnt));
        exp_c.delete();
        exp_i.delete();
        exp_f.delete();
        exp_t.delete();
    endtask

    initial begin
        reset_i      = 1'b1;
        bus.w_v_i    = 1'b0;
        bus.w_addr_i = '0;
        bus.w_data_i = '0;
        bus.start_i  = 1'b0;
        do_reset();

        // Reset values
        check("rst_commit_v", 64'(bus.commit_v_o), 64'd0);
        check("rst_ird_v", 64'(bus.ird_w_v_o), 64'd0);
        check("rst_frd_v", 64'(bus.frd_w_v_o), 64'd0);
        check("rst_trap_v", 64'(bus.trap_v_o), 64'd0);
        check("rst_done", 64'(bus.done_o), 64'd0);
        check("rst_cnt", 64'(bus.commit_cnt_o), 64'd0);
        check("rst_pc", 64'(bus.commit_pc_o), 64'd0);

        // Three back-to-back early int writes
        wr(0, mk(4'd0, 3'd1, 5'd1, 39'h1000, 32'h0000_0093, 64'h11));
        wr(1, mk(4'd0, 3'd1, 5'd2, 39'h1004, 32'h0000_0113, 64'h22));
        wr(2, mk(4'd0, 3'd1, 5'd3, 39'h1008, 32'h0000_0193, 64'h33));
        wr(3, mk(4'd0, 3'd6, 5'd0, 39'h0, 32'h0, 64'h0));
        exp_c.push_back(ev(1, 64'h1000, 64'h93));
        exp_c.push_back(ev(2, 64'h1004, 64'h113));
        exp_c.push_back(ev(3, 64'h1008, 64'h193));
        exp_i.push_back(ev(1, 64'd1, 64'h11));
        exp_i.push_back(ev(2, 64'd2, 64'h22));
        exp_i.push_back(ev(3, 64'd3, 64'h33));
        start_run();
        finish_run("seq3", 3);
        // start in DONE must produce nothing
        @(negedge clk);
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (6) @(negedge clk);
        check("done_sticky", 64'(bus.done_o), 64'd1);

        // Late int write stalls the following int commit
        do_reset();
        wr(0, mk(4'd0, 3'd3, 5'd5, 39'h2000, 32'h1111_1111, 64'hAB));
        wr(1, mk(4'd0, 3'd1, 5'd6, 39'h2004, 32'h2222_2222, 64'h66));
        wr(2, mk(4'd0, 3'd7, 5'd0, 39'h0, 32'h0, 64'h0));
        exp_c.push_back(ev(1, 64'h2000, 64'h1111_1111));
        exp_c.push_back(ev(5, 64'h2004, 64'h2222_2222));
        exp_i.push_back(ev(4, 64'd5, 64'hAB));
        exp_i.push_back(ev(5, 64'd6, 64'h66));
        start_run();
        finish_run("late_int", 2);

        // Late FP write does not stall an int commit
        do_reset();
        wr(0, mk(4'd0, 3'd4, 5'd7, 39'h3000, 32'h3333_3333, 64'h4000_0000_0000_0000));
        wr(1, mk(4'd0, 3'd1, 5'd8, 39'h3004, 32'h4444_4444, 64'h88));
        wr(2, mk(4'd0, 3'd6, 5'd0, 39'h0, 32'h0, 64'h0));
        exp_c.push_back(ev(1, 64'h3000, 64'h3333_3333));
        exp_c.push_back(ev(2, 64'h3004, 64'h4444_4444));
        exp_i.push_back(ev(2, 64'd8, 64'h88));
        exp_f.push_back(ev(4, 64'd7, 64'h4000_0000_0000_0000));
        start_run();
        finish_run("late_fp", 2);

        // Trap (no commit) then a no-write commit
        do_reset();
        wr(0, mk(4'd0, 3'd5, 5'd0, 39'h4000, 32'h5555_5555, 64'h8));
        wr(1, mk(4'd0, 3'd0, 5'd3, 39'h4004, 32'h6666_6666, 64'h77));
        wr(2, mk(4'd0, 3'd6, 5'd0, 39'h0, 32'h0, 64'h0));
        exp_t.push_back(ev(1, 64'h8, 64'd0));
        exp_c.push_back(ev(2, 64'h4004, 64'h6666_6666));
        start_run();
        finish_run("trap", 1);

        // Gaps: 5 before record 0, 2 before record 1
        do_reset();
        wr(0, mk(4'd5, 3'd1, 5'd4, 39'h5000, 32'h7777_7777, 64'h44));
        wr(1, mk(4'd2, 3'd1, 5'd10, 39'h5004, 32'h8888_8888, 64'hA0));
        wr(2, mk(4'd0, 3'd6, 5'd0, 39'h0, 32'h0, 64'h0));
        exp_c.push_back(ev(6, 64'h5000, 64'h7777_7777));
        exp_c.push_back(ev(9, 64'h5004, 64'h8888_8888));
        exp_i.push_back(ev(6, 64'd4, 64'h44));
        exp_i.push_back(ev(9, 64'd10, 64'hA0));
        start_run();
        finish_run("gap", 2);

        // Reset while a late slot is pending; writes and start outside IDLE are ignored
        do_reset();
        wr(0, mk(4'd0, 3'd3, 5'd5, 39'h6000, 32'h9999_9999, 64'hAB));
        wr(1, mk(4'd0, 3'd6, 5'd0, 39'h0, 32'h0, 64'h0));
        exp_c.push_back(ev(1, 64'h6000, 64'h9999_9999));
        start_run();
        @(negedge clk);
        bus.w_v_i    = 1'b1;
        bus.w_addr_i = 6'd0;
        bus.w_data_i = mk(4'd0, 3'd1, 5'd9, 39'h7777, 32'hDEAD_BEEF, 64'hEE);
        bus.start_i  = 1'b1;
        @(negedge clk);
        bus.w_v_i    = 1'b0;
        bus.start_i  = 1'b0;
        reset_i      = 1'b1;
        @(negedge clk);
        reset_i      = 1'b0;
        check("midrst_cnt", 64'(bus.commit_cnt_o), 64'd0);
        check("midrst_done", 64'(bus.done_o), 64'd0);
        check("midrst_ird", 64'(bus.ird_w_v_o), 64'd0);
        repeat (8) @(negedge clk);
        check("midrst_left", 64'(exp_c.size() + exp_i.size()), 64'd0);
        exp_c.push_back(ev(1, 64'h6000, 64'h9999_9999));
        exp_i.push_back(ev(4, 64'd5, 64'hAB));
        start_run();
        finish_run("replay", 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/bp_nonsynth_commit_driver.md
# bp_nonsynth_commit_driver

Testbench-side producer of the commit / writeback event stream that the core's cosim checker consumes. It replays a preloaded table of commit records, emitting commit pulses, early and late integer/FP writebacks and traps. Writebacks stay in order per register file, so a downstream in-order matcher can pair every write with its commit. It sits in the nonsynth test harness in place of the backend, for checker bring-up and regression.

## Interface
- bp_params_p, e_bp_default_cfg: supplies vaddr_width_p, instr_width_p (32), dword_width_p (64).
- els_p, 64: record table depth.
- late_delay_p, 3: cycles from a late commit to its writeback; legal range 1..15.
- Record layout, MSB to LSB: gap[3:0], kind[2:0], rd[4:0], pc[vaddr_width_p-1:0], instr[31:0], data[63:0].
- kind values: 0 = no write, 1 = int early, 2 = fp early, 3 = int late, 4 = fp late, 5 = trap (data is the cause), 6/7 = end marker.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- w_v_i  in  1  table write strobe; accepted only in IDLE
- w_addr_i  in  clog2(els_p)  table write index
- w_data_i  in  record width  record to write
- start_i  in  1  begin replay from index 0; sampled in IDLE
- commit_v_o  out  1  commit pulse
- commit_pc_o  out  vaddr_width_p  committed pc
- commit_instr_o  out  32  committed instruction
- ird_w_v_o / ird_addr_o / ird_data_o  out  1 / 5 / 64  integer writeback
- frd_w_v_o / frd_addr_o / frd_data_o  out  1 / 5 / 64  FP writeback, raw IEEE bits
- trap_v_o / cause_o  out  1 / 64  trap event
- done_o  out  1  replay finished (sticky until reset)
- commit_cnt_o  out  32  number of commit pulses emitted

## Operation
- States: IDLE, GAP, ISSUE, DRAIN, DONE. Reset enters IDLE.
- IDLE: table is writable. start_i moves to GAP with idx=0 and loads the gap counter from record[0].gap.
- GAP: counts down to 0, then goes to ISSUE. A gap of 0 goes straight to ISSUE with no extra cycle.
- ISSUE on an end marker or idx==els_p: go to DRAIN.
- ISSUE otherwise: issue the record when legal, then idx++, load the next gap, and go to GAP.
- Issue legality:
  - Int-writing kinds (1, 3) stall while a late int writeback is pending.
  - FP kinds (2, 4) stall while a late FP writeback is pending.
  - Kinds 0 and 5 never stall.
  - This rule keeps the int and FP writeback order equal to commit order.
- Issue actions by kind:
  - Kinds 0–4 raise commit_v with pc and instr.
  - Kind 1: ird_w_v, rd and data in the same cycle.
  - Kind 2: frd_w_v, rd and data in the same cycle.
  - Kind 3: arms the int pending slot with {rd, data} and counter = late_delay_p.
  - Kind 4: arms the FP pending slot with {rd, data} and counter = late_delay_p.
  - Kind 5: trap_v with cause = data; no commit_v.
- Pending slot: one per class. The counter decrements each cycle. At 0, the slot drives its writeback port for one cycle and clears.
- A slot firing in the same cycle as an other-class early write is legal; both ports are active.
- A slot firing in the same cycle a same-class record is waiting: the record issues the next cycle, never in that cycle.
- DRAIN: wait until both slots are clear, then go to DONE.
- DONE: done_o=1 and all strobes are 0. Leave only via reset.
- commit_cnt_o increments on every commit_v_o pulse and saturates at 2^32-1.

## Timing
- All outputs are registered. The issue decision in cycle N appears on the outputs in cycle N+1.
- A late writeback appears exactly late_delay_p cycles after its commit_v_o.
- Minimum spacing is one issued record per cycle when gap=0 and nothing stalls.
- Reset values: every strobe, done_o and commit_cnt_o are 0; data outputs are 0.
- Reset asserted mid-replay clears state and pending slots on the next edge, with no further strobes. Table contents are retained.
- start_i outside IDLE is ignored. w_v_i outside IDLE is ignored.

## Test plan
- Three kind-1 records (rd=1,2,3; data=0x11,0x22,0x33; gap=0), then end → commit_v high for 3 consecutive cycles with matching ird writes, then done_o; commit_cnt_o=3.
- Kind-3 record (rd=5, data=0xAB) with late_delay_p=3, followed by a kind-1 record:
  - ird_w_v for rd5 fires 3 cycles after the first commit.
  - The second commit stalls until that cycle passes, then issues.
  - Int writeback order is 5 then the second rd.
- Kind-4 record then a kind-1 record, gap=0 → no stall; the int commit issues the next cycle and frd fires 3 cycles after the FP commit.
- Kind-5 record with data=0x8 → trap_v with cause 0x8 and no commit_v; commit_cnt_o unchanged.
- gap=5 on record 0 → first commit_v appears 5 cycles later than with gap=0.
- reset_i pulsed while a late slot is pending → no writeback emitted, state is IDLE; a new start_i replays from index 0 with identical output.
